// File: rtl/cpu_ctrl_fsm_ws.sv
// cpu_ctrl_fsm_ws: multicycle RISC control FSM with memory wait states, access timeout, resumable HALT and error state.
// Ports: clk_i/reset_i (sync, active-high); opcode_i/op_i from IR[15:11]; mem_ready_i access handshake;
//   resume_i leaves HALT; *_o datapath/PC/memory strobes, one-hot register/writeback selects, halt_o/err_o
//   status, instr_count_o/stall_count_o performance counters (live only when PERF_CNT_EN is defined).
// Macro: PERF_CNT_EN enables the saturating instruction/stall counters; undefined ties them to 0.
module cpu_ctrl_fsm_ws #(
    parameter int WAIT_CYCLES = 0,
    parameter int TIMEOUT     = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [2:0]       opcode_i,
    input  logic [1:0]       op_i,
    input  logic             mem_ready_i,
    input  logic             resume_i,
    output logic             pc_reset_o,
    output logic             pc_load_o,
    output logic             ir_load_o,
    output logic             addr_sel_o,
    output logic             write_o,
    output logic             loada_o,
    output logic             loadb_o,
    output logic             loadc_o,
    output logic             loads_o,
    output logic             loadm_o,
    output logic             asel_o,
    output logic             bsel_o,
    output logic             csel_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       mem_cmd_o,
    output logic [2:0]       reg_w_sel_o,
    output logic [2:0]       reg_a_sel_o,
    output logic [2:0]       reg_b_sel_o,
    output logic [3:0]       vsel_o,
    output logic             halt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [CNT_W-1:0] stall_count_o
);
    typedef enum logic [3:0] {S_RESET, S_IF, S_DEC, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR} state_t;
    localparam logic [15:0] WAIT_L = 16'(WAIT_CYCLES);
    localparam logic [16:0] TO_L   = 17'(TIMEOUT);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        acc, done, tout;
    logic        is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_b, is_bl, is_bx, is_blx, is_hlt;
    assign is_movi = opcode_i == 3'b110 && op_i == 2'b10;
    assign is_movr = opcode_i == 3'b110 && op_i != 2'b10;
    assign is_alu  = opcode_i == 3'b101;
    assign is_cmp  = is_alu && op_i == 2'b01;
    assign is_ldr  = opcode_i == 3'b011;
    assign is_str  = opcode_i == 3'b100;
    assign is_b    = opcode_i == 3'b001;
    assign is_bl   = opcode_i == 3'b010 && op_i == 2'b11;
    assign is_bx   = opcode_i == 3'b010 && op_i == 2'b00;
    assign is_blx  = opcode_i == 3'b010 && op_i == 2'b10;
    assign is_hlt  = opcode_i == 3'b111;
    assign acc  = state_q == S_IF || state_q == S_MEM;
    assign done = acc && cnt_q >= WAIT_L && mem_ready_i;
    // The counter value after this stalled cycle reaching TIMEOUT aborts the access.
    assign tout = TIMEOUT != 0 && acc && !done && ({1'b0, cnt_q} + 17'd1 >= TO_L);
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_IF;
            S_IF:    state_d = done ? S_DEC : tout ? S_ERR : S_IF;
            S_DEC:   state_d = (is_movi || is_b || is_bl) ? S_IF : is_hlt ? S_HALT :
                               (is_movr || is_alu || is_ldr || is_str || is_bx || is_blx) ? S_EXEC : S_ERR;
            S_EXEC:  state_d = (is_cmp || is_bx || is_blx) ? S_IF : (is_ldr || is_str) ? S_MEM : S_WB;
            S_MEM:   state_d = done ? (is_ldr ? S_WB : S_IF) : tout ? S_ERR : S_MEM;
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = resume_i ? S_IF : S_HALT;
            default: state_d = S_ERR;
        endcase
        cnt_d = (acc && state_d == state_q) ? ((&cnt_q) ? cnt_q : cnt_q + 16'd1) : '0;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        {pc_reset_o, pc_load_o, ir_load_o, addr_sel_o, write_o, loada_o, loadb_o} = '0;
        {loadc_o, loads_o, loadm_o, asel_o, bsel_o, csel_o, halt_o, err_o} = '0;
        pc_sel_o = 2'b00;
        mem_cmd_o = 2'b00;
        reg_w_sel_o = 3'b000;
        reg_a_sel_o = 3'b000;
        reg_b_sel_o = 3'b000;
        vsel_o = 4'b0000;
        case (state_q)
            S_RESET: begin
                pc_reset_o = 1'b1;
                pc_load_o  = 1'b1;
            end
            S_IF: begin
                addr_sel_o = 1'b1;
                mem_cmd_o  = 2'b10;
                ir_load_o  = done;
                pc_load_o  = done;
            end
            S_DEC: begin
                if (is_movi) begin
                    reg_w_sel_o = 3'b100;
                    write_o     = 1'b1;
                    vsel_o      = 4'b0100;
                end
                if (is_movr) begin
                    reg_b_sel_o = 3'b001;
                    loadb_o     = 1'b1;
                end
                if (is_alu) begin
                    reg_a_sel_o = 3'b100;
                    reg_b_sel_o = 3'b001;
                    loada_o     = 1'b1;
                    loadb_o     = 1'b1;
                end
                if (is_ldr) begin
                    reg_a_sel_o = 3'b100;
                    loada_o     = 1'b1;
                end
                if (is_str) begin
                    reg_a_sel_o = 3'b100;
                    reg_b_sel_o = 3'b010;
                    loada_o     = 1'b1;
                    loadb_o     = 1'b1;
                end
                if (is_b) begin
                    pc_load_o = 1'b1;
                    pc_sel_o  = 2'b01;
                end
                if (is_bl) begin
                    pc_load_o   = 1'b1;
                    pc_sel_o    = 2'b11;
                    reg_w_sel_o = 3'b100;
                    write_o     = 1'b1;
                    vsel_o      = 4'b1000;
                end
                if (is_bx || is_blx) begin
                    reg_b_sel_o = 3'b010;
                    loadc_o     = 1'b1;
                    csel_o      = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_movr) begin
                    loadc_o = 1'b1;
                    asel_o  = 1'b1;
                end
                // CMP only updates status flags, never the C register.
                if (is_alu) begin
                    loadc_o = !is_cmp;
                    loads_o = is_cmp;
                end
                if (is_ldr) begin
                    loadm_o = 1'b1;
                    bsel_o  = 1'b1;
                end
                if (is_str) begin
                    loadc_o = 1'b1;
                    loadm_o = 1'b1;
                    bsel_o  = 1'b1;
                    csel_o  = 1'b1;
                end
                if (is_bx || is_blx) begin
                    pc_load_o = 1'b1;
                    pc_sel_o  = 2'b10;
                end
                if (is_blx) begin
                    reg_w_sel_o = 3'b100;
                    write_o     = 1'b1;
                    vsel_o      = 4'b1000;
                end
            end
            S_MEM:   mem_cmd_o = is_str ? 2'b01 : 2'b10;
            S_WB: begin
                reg_w_sel_o = 3'b010;
                write_o     = 1'b1;
                vsel_o      = is_ldr ? 4'b0010 : 4'b0001;
                mem_cmd_o   = is_ldr ? 2'b10 : 2'b00;
            end
            S_HALT:  halt_o = 1'b1;
            S_ERR:   err_o = 1'b1;
            default: ;
        endcase
    end
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instr_q, stall_q;
    logic             enter_if;
    assign enter_if = state_d == S_IF && state_q inside {S_DEC, S_EXEC, S_MEM, S_WB, S_HALT};
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (enter_if && !(&instr_q)) instr_q <= instr_q + 1'b1;
            if (acc && !done && !(&stall_q)) stall_q <= stall_q + 1'b1;
        end
    end
    assign instr_count_o = instr_q;
    assign stall_count_o = stall_q;
`else
    assign instr_count_o = '0;
    assign stall_count_o = '0;
`endif
endmodule

// File: doc/cpu_ctrl_fsm_ws.md
Name: cpu_ctrl_fsm_ws

Overview:
Multicycle control FSM for the simple RISC datapath, successor to the fixed-timing controller. Adds parametrised memory wait states with a mem_ready handshake, an access timeout, resumable HALT and an illegal-opcode error state. It sits between the instruction register decode (opcode/op) and the datapath/PC/memory control inputs.

Parameters:
WAIT_CYCLES, 0, minimum extra cycles each memory access is held before mem_ready is sampled.
TIMEOUT, 0, maximum cycles one access may stall awaiting mem_ready; 0 disables the timeout.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
mem_ready  in  1  memory completes the current access this cycle
resume  in  1  leave HALT
pc_reset, pc_load, ir_load, addr_sel, write, loada, loadb, loadc, loads, loadm, asel, bsel, csel  out  1 each  datapath/PC strobes
pc_sel  out  2  00 PC+1, 01 branch target, 10 Rd via C, 11 PC+1+sximm8 with link
mem_cmd  out  2  00 none, 10 read, 01 write
reg_w_sel, reg_a_sel, reg_b_sel  out  3 each  one-hot Rn=100, Rd=010, Rm=001
vsel  out  4  one-hot writeback source
halt, err  out  1 each  status
instr_count, stall_count  out  CNT_W each  performance counters

Behaviour:
- All outputs are combinational from state, opcode, op and the wait logic. Default is 0.
- States: RESET, IF, DECODE, EXEC, MEM, WB, HALT, ERROR. The encoding is 4 bits.
- reset=1 moves to RESET on the next edge from any state, including mid-access. It clears the wait counter, err and the counters.
- RESET asserts pc_reset and pc_load, then goes to IF.
- Access states are IF (read, addr_sel=1) and MEM (read for LDR, write for STR, addr_sel=0). mem_cmd is held stable for the whole access.
- A wait counter counts cycles in the access state. Completion happens in the first cycle where the counter is at least WAIT_CYCLES and mem_ready=1.
- IF completion pulses ir_load and pc_load (pc_sel=00) in that cycle only, then goes to DECODE.
- An access is incomplete when mem_ready=0 or the wait count is below WAIT_CYCLES. In that case the FSM stays put and no load strobes fire.
- If TIMEOUT>0 and the counter reaches TIMEOUT without completion, the FSM goes to ERROR.
- Per-instruction sequences (signals asserted per state; every sequence ends by returning to IF):
  - MOV imm (110_10):
    - DECODE: reg_w_sel=100, write, vsel=0100.
  - MOV reg (110_00):
    - DECODE: reg_b_sel=001, loadb.
    - EXEC: loadc, asel.
    - WB: reg_w_sel=010, write, vsel=0001.
  - ALU (101_xx):
    - DECODE: reg_a_sel=100, reg_b_sel=001, loada, loadb.
    - EXEC: loadc, then WB as MOV reg. Exception: CMP (op=01) asserts loads in EXEC and goes straight to IF.
  - LDR (011):
    - DECODE: reg_a_sel=100, loada.
    - EXEC: loadm, bsel.
    - MEM: read.
    - WB: mem_cmd=10, reg_w_sel=010, write, vsel=0010.
  - STR (100):
    - DECODE: reg_a_sel=100, reg_b_sel=010, loada, loadb.
    - EXEC: loadc, loadm, bsel, csel.
    - MEM: write.
  - B/Bcond (001):
    - DECODE: pc_load, pc_sel=01.
  - BL (010_11):
    - DECODE: pc_load, pc_sel=11, reg_w_sel=100, write, vsel=1000.
  - BX (010_00):
    - DECODE: reg_b_sel=010, loadc, csel.
    - EXEC: pc_load, pc_sel=10.
  - BLX (010_10):
    - DECODE as BX.
    - EXEC: pc_load, pc_sel=10, reg_w_sel=100, write, vsel=1000.
  - HALT (111):
    - DECODE goes to HALT.
    - HALT asserts halt and stays until resume=1, then goes to IF (PC already advanced).
    - reset takes priority over resume.
- Illegal opcodes (000_xx, 010_01) go from DECODE to ERROR. ERROR asserts err and no strobes, and is left only by reset.

Optional Feature:
PERF_CNT_EN:
- Defined:
  - instr_count increments on every transition into IF from DECODE, EXEC, MEM, WB or HALT.
  - stall_count increments each cycle an access is held incomplete.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- WAIT_CYCLES=0, mem_ready=1, reset then MOV R0,#5 -> RESET→IF→DECODE. ir_load pulses once on the IF cycle. write=1 with vsel=0100 in DECODE. Back in IF on cycle 4.
- WAIT_CYCLES=2, mem_ready=1 -> IF lasts exactly 3 cycles. ir_load and pc_load are high only in the 3rd. stall_count=2 with PERF_CNT_EN.
- LDR with mem_ready low for 5 MEM cycles -> mem_cmd=10 held 6 cycles, then WB with write=1 and vsel=0010.
- TIMEOUT=4, mem_ready stuck 0 in IF -> ERROR after 4 cycles with err=1. reset clears err and returns to RESET.
- HALT opcode -> halt=1 held for 10 cycles. resume pulse -> IF next cycle, halt=0.
- reset asserted during STR MEM -> RESET next edge with mem_cmd=00. Opcode 000 -> ERROR.
